// File: rtl/io_walk_checker.sv
// Receive-side checker for a remote walking-one across a pin bank.
// Filters the synchronized pins, tracks the expected index, and latches the first fault.
module io_walk_checker #(
  parameter int NUM_PINS       = 103,
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_PINS-1:0]           pins_i,
  input  logic                          clear_i,
  output logic                          locked_o,
  output logic                          pass_o,
  output logic [15:0]                   pass_count_o,
  output logic                          error_o,
  output logic [1:0]                    err_kind_o,
  output logic [$clog2(NUM_PINS)-1:0]   err_idx_o
);

  localparam int IDX_W = $clog2(NUM_PINS);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [NUM_PINS-1:0] PIN_ONE   = NUM_PINS'(1);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(NUM_PINS - 1);
  localparam logic [CNT_W-1:0]    SETTLED   = CNT_W'(SETTLE_CYCLES);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]          KIND_SHORT = 2'b01;
  localparam logic [1:0]          KIND_SEQ   = 2'b10;
  localparam logic [1:0]          KIND_OPEN  = 2'b11;

  typedef enum logic [1:0] {HUNT, TRACK, FAULT} state_t;

  state_t state, state_next;

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] s, prev_s, last_acc;
  logic [CNT_W-1:0]    stab_cnt;
  logic                new_stable;

  logic                is_zero, is_multi, is_onehot;
  logic                low_found, short_found;
  logic [IDX_W-1:0]    low_idx, short_idx;

  logic [IDX_W-1:0]    expected;
  logic [TO_W-1:0]     to_cnt;
  logic                timeout_hit;
  logic                accept;
  logic [1:0]          fault_kind;
  logic [IDX_W-1:0]    fault_idx;

  logic                pass_q;
  logic [15:0]         pass_count;
  logic [1:0]          err_kind;
  logic [IDX_W-1:0]    err_idx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '{default: '0};
    end else if (clear_i) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= pins_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // An event needs s steady for SETTLE_CYCLES and different from the last accepted pattern.
  assign new_stable = (stab_cnt == SETTLED) && (s == prev_s) && (s != last_acc);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_s   <= '0;
      stab_cnt <= '0;
      last_acc <= '0;
    end else if (clear_i) begin
      prev_s   <= '0;
      stab_cnt <= '0;
      last_acc <= '0;
    end else begin
      prev_s <= s;
      if (s != prev_s) begin
        stab_cnt <= '0;
      end else if (stab_cnt != SETTLED) begin
        stab_cnt <= stab_cnt + CNT_W'(1);
      end
      if (new_stable) last_acc <= s;
    end
  end

  always_comb begin
    is_zero     = (s == '0);
    is_multi    = !is_zero && ((s & (s - PIN_ONE)) != '0);
    is_onehot   = !is_zero && !is_multi;
    low_found   = 1'b0;
    short_found = 1'b0;
    low_idx     = '0;
    short_idx   = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (s[i] && !low_found) begin
        low_idx   = IDX_W'(i);
        low_found = 1'b1;
      end
      if (s[i] && !short_found && (IDX_W'(i) != expected)) begin
        short_idx   = IDX_W'(i);
        short_found = 1'b1;
      end
    end
  end

  assign timeout_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= HUNT;
    end else if (clear_i) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // Events take precedence over a coincident timeout; an accept discards it.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fault_kind = 2'b00;
    fault_idx  = '0;
    case (state)
      HUNT: begin
        if (new_stable && is_onehot && (low_idx == '0)) state_next = TRACK;
      end
      TRACK: begin
        if (new_stable && is_multi) begin
          state_next = FAULT;
          fault_kind = KIND_SHORT;
          fault_idx  = short_idx;
        end else if (new_stable && is_onehot && (low_idx == expected)) begin
          accept = 1'b1;
        end else if (new_stable && is_onehot) begin
          state_next = FAULT;
          fault_kind = KIND_SEQ;
          fault_idx  = low_idx;
        end else if (timeout_hit) begin
          state_next = FAULT;
          fault_kind = KIND_OPEN;
          fault_idx  = expected;
        end
      end
      FAULT: state_next = FAULT;
      default: state_next = HUNT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      expected   <= '0;
      to_cnt     <= '0;
      pass_q     <= 1'b0;
      pass_count <= '0;
      err_kind   <= '0;
      err_idx    <= '0;
    end else if (clear_i) begin
      expected   <= '0;
      to_cnt     <= '0;
      pass_q     <= 1'b0;
      pass_count <= '0;
      err_kind   <= '0;
      err_idx    <= '0;
    end else begin
      pass_q <= 1'b0;
      case (state)
        HUNT: begin
          to_cnt <= '0;
          if (state_next == TRACK) expected <= IDX_W'(1);
        end
        TRACK: begin
          if (accept) begin
            to_cnt <= '0;
            if (expected == LAST_IDX) begin
              expected <= '0;
              pass_q   <= 1'b1;
              if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
            end else begin
              expected <= expected + IDX_W'(1);
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
          if (state_next == FAULT) begin
            err_kind <= fault_kind;
            err_idx  <= fault_idx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    locked_o     = (state == TRACK);
    error_o      = (state == FAULT);
    pass_o       = pass_q;
    pass_count_o = pass_count;
    err_kind_o   = err_kind;
    err_idx_o    = err_idx;
  end

endmodule

// File: tb/tb_io_walk_checker.sv
// Directed bench for io_walk_checker: an 8-pin instance for walk/fault/clear/reset
// scenarios and a 2-pin instance for pass counter saturation.
module tb_io_walk_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear;
  logic [7:0] pins;
  logic       locked, pass, error;
  logic [15:0] pass_count;
  logic [1:0] err_kind;
  logic [2:0] err_idx;

  logic       s_rst_n, s_clear;
  logic [1:0] s_pins;
  logic       s_locked, s_pass, s_error;
  logic [15:0] s_count;
  logic [1:0] s_kind;
  logic [0:0] s_idx;

  int total = 0;
  int bad = 0;
  int pass_seen = 0;
  int s_pass_seen = 0;

  io_walk_checker #(.NUM_PINS(8), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .pins_i(pins), .clear_i(clear),
    .locked_o(locked), .pass_o(pass), .pass_count_o(pass_count),
    .error_o(error), .err_kind_o(err_kind), .err_idx_o(err_idx)
  );

  io_walk_checker #(.NUM_PINS(2), .SYNC_STAGES(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut_sat (
    .clk_i(clk), .rst_ni(s_rst_n), .pins_i(s_pins), .clear_i(s_clear),
    .locked_o(s_locked), .pass_o(s_pass), .pass_count_o(s_count),
    .error_o(s_error), .err_kind_o(s_kind), .err_idx_o(s_idx)
  );

  always @(negedge clk) begin
    if (pass) pass_seen++;
    if (s_pass) s_pass_seen++;
  end

  typedef struct {
    logic [7:0] pat;
    int         hold;
    logic       lck;
    int         cnt;
    int         pass_edge;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] pat, input int hold);
    pins = pat;
    step(hold);
  endtask

  task automatic walkTo(input int n);
    for (int k = 0; k < n; k++) applyStimulus(8'(1) << k, 10);
  endtask

  task automatic checkState(input string tag, input logic l, input logic e, input logic [1:0] k,
                            input logic [2:0] idx, input logic [15:0] c);
    checkOutput({tag, "_locked"}, locked, l);
    checkOutput({tag, "_error"}, error, e);
    checkOutput({tag, "_kind"}, err_kind, k);
    checkOutput({tag, "_idx"}, err_idx, idx);
    checkOutput({tag, "_count"}, pass_count, c);
  endtask

  initial begin
    vec_t v;
    int   p0;

    rst_n = 1'b0; clear = 1'b0; pins = '0;
    s_rst_n = 1'b0; s_clear = 1'b0; s_pins = '0;

    // Table: gap after the hand-driven index 0, then the rest of two full walks.
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        if (!(w == 0 && k == 0)) begin
          v.pat = 8'(1) << k; v.hold = 10; v.lck = 1'b1;
          v.cnt = (k == 7) ? w + 1 : w; v.pass_edge = (k == 7) ? 8 : 0;
          vecs.push_back(v);
        end
        v.pat = 8'h00; v.hold = 3; v.lck = 1'b1;
        v.cnt = (k == 7) ? w + 1 : w; v.pass_edge = 0;
        vecs.push_back(v);
      end
    end

    step(2);
    checkState("reset", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);
    checkOutput("reset_pass", pass, 1'b0);
    rst_n = 1'b1; s_rst_n = 1'b1;
    step(2);

    pins = 8'h01;
    step(7);
    checkOutput("lat_lock_edge7", locked, 1'b0);
    step(1);
    checkOutput("lat_lock_edge8", locked, 1'b1);
    step(2);

    for (int i = 0; i < vecs.size(); i++) begin
      pins = vecs[i].pat;
      for (int e = 1; e <= vecs[i].hold; e++) begin
        step(1);
        checkOutput($sformatf("walk_v%0d_e%0d_pass", i, e), pass, (e == vecs[i].pass_edge));
      end
      checkState($sformatf("walk_v%0d", i), vecs[i].lck, 1'b0, 2'b00, 3'd0, 16'(vecs[i].cnt));
    end
    checkOutput("walk_pass_pulses", pass_seen, 2);

    // Short at expected=3: bits 3 and 4 together.
    walkTo(3);
    applyStimulus(8'h18, 10);
    checkState("short", 1'b0, 1'b1, 2'b01, 3'd4, 16'd2);
    applyStimulus(8'h08, 10);
    applyStimulus(8'h10, 10);
    checkState("short_frozen", 1'b0, 1'b1, 2'b01, 3'd4, 16'd2);

    clear = 1'b1;
    step(1);
    clear = 1'b0;
    checkState("clear", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);
    checkOutput("clear_pass", pass, 1'b0);

    p0 = pass_seen;
    walkTo(8);
    applyStimulus(8'h00, 3);
    checkState("fresh_walk", 1'b1, 1'b0, 2'b00, 3'd0, 16'd1);
    checkOutput("fresh_walk_pulses", pass_seen - p0, 1);

    // Asynchronous reset in the middle of a walk, away from any clock edge.
    walkTo(4);
    #3;
    rst_n = 1'b0;
    #1;
    checkState("async_reset", 1'b0, 1'b0, 2'b00, 3'd0, 16'd0);
    checkOutput("async_reset_pass", pass, 1'b0);
    #2;
    rst_n = 1'b1;
    step(1);
    applyStimulus(8'h10, 10);
    checkOutput("post_reset_idx4_ignored", locked, 1'b0);
    applyStimulus(8'h01, 10);
    checkOutput("post_reset_idx0_locks", locked, 1'b1);

    applyStimulus(8'h02, 10);
    applyStimulus(8'h08, 10);
    checkState("seq_skip", 1'b0, 1'b1, 2'b10, 3'd3, 16'd0);

    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // Index 4 accepted 8 edges after it is driven; OPEN due 64 edges later.
    walkTo(4);
    pins = 8'h10;
    step(10);
    pins = 8'h40;
    step(2);
    pins = 8'h00;
    step(59);
    checkState("open_edge71", 1'b1, 1'b0, 2'b00, 3'd0, 16'd0);
    step(1);
    checkState("open_edge72", 1'b0, 1'b1, 2'b11, 3'd5, 16'd0);

    // Saturation on the 2-pin instance, preloaded near the top of the count.
    force dut_sat.pass_count = 16'hFFFE;
    step(1);
    release dut_sat.pass_count;
    step(1);
    checkOutput("sat_preload", s_count, 16'hFFFE);
    p0 = s_pass_seen;
    for (int w = 0; w < 3; w++) begin
      s_pins = 2'b01;
      step(10);
      s_pins = 2'b10;
      step(10);
      checkOutput($sformatf("sat_count_walk%0d", w), s_count, 16'hFFFF);
      checkOutput($sformatf("sat_pulses_walk%0d", w), s_pass_seen - p0, w + 1);
    end
    checkOutput("sat_error", s_error, 1'b0);
    checkOutput("sat_locked", s_locked, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
